period_monitor: RTL and testbench
=================================

# period_monitor

Synchronous frequency/period checker: the receive-side counterpart of the team's clock dividers. It samples a divided or externally generated square wave, measures period and high time in `clk` cycles between rising edges, and declares lock after a run of in-tolerance periods. It flags missing edges with a sticky timeout. It sits beside divider outputs and recovered clocks as a built-in self-check and status source.

## Interface
- `CNT_W`, 8, width of the period, high-time and internal counters
- `EXP_PERIOD`, 3, expected period in `clk` cycles
- `TOL`, 0, allowed absolute deviation from `EXP_PERIOD` (inclusive)
- `LOCK_CNT`, 4, consecutive matching periods required for lock (≥1)
- `TIMEOUT`, 255, cycles without a rising edge before timeout; 2 ≤ `TIMEOUT` ≤ 2^`CNT_W`−1

- `clk`  in  1  single clock
- `reset`  in  1  synchronous, active-high reset
- `sig_in`  in  1  monitored signal; asynchronous, synchronized internally
- `clear`  in  1  synchronous; drops lock, clears `timeout_err`, returns to SEEK
- `period`  out  `CNT_W`  last measured period; reset value 0
- `high_time`  out  `CNT_W`  cycles `sig_in` was sampled high in the last period; reset value 0
- `period_valid`  out  1  one-cycle pulse when `period`/`high_time` update; reset value 0
- `mismatch`  out  1  one-cycle pulse: last period out of tolerance; reset value 0
- `locked`  out  1  level, FSM in LOCKED; reset value 0
- `timeout_err`  out  1  sticky until `clear`/`reset`; reset value 0

## Operation
- Synchronizer: `s1`→`s2` two-flop chain, plus `s3` delayed copy. `rise = s2 & ~s3`.
- Cycle counter `cnt`:
  - on `rise`, `cnt <= 1`
  - otherwise `cnt <= cnt+1`, saturating at `TIMEOUT`
- High counter `hcnt`:
  - on `rise`, `hcnt <= 1`
  - else if `s2`, `hcnt <= hcnt+1`, saturating at 2^`CNT_W`−1
- Measurement:
  - At a rise outside SEEK, `period <= cnt` and `high_time <= hcnt`.
  - `period_valid` pulses. `match = |period − EXP_PERIOD| ≤ TOL`, computed at `CNT_W+1` bits with no wrap.
- FSM `match_cnt` counts 0..`LOCK_CNT`:
  - **SEEK:** no reference edge yet. A rise moves to MEASURE without `period_valid`.
  - **MEASURE:**
    - On a match rise, `match_cnt+1`. Reaching `LOCK_CNT` moves to LOCKED.
    - On a mismatch rise, `match_cnt <= 0` and `mismatch` pulses.
  - **LOCKED:** a mismatch rise moves to MEASURE, `match_cnt <= 0`, `mismatch` pulses.
  - **Timeout (MEASURE/LOCKED):** `cnt == TIMEOUT` with no rise this cycle sets `timeout_err <= 1`, goes to SEEK, `match_cnt <= 0`.
- Priority: `reset` > `clear` > timeout > rise.
  - `clear` coinciding with a rise discards that rise; the next rise is a SEEK reference.
  - A rise with `cnt == TIMEOUT` is a normal measurement, `period = TIMEOUT`, not a timeout.
- `timeout_err` is cleared only by `clear`/`reset`, never by new edges.
- `reset` mid-operation: all state and outputs return to reset values at that edge; FSM goes to SEEK.

## Timing
- All outputs are registered; no combinational path from input to output.
- Edge-detect latency: `sig_in` high at edge k gives `s2=1` after k+1 and `rise` in the cycle after k+1. Outputs update at edge k+2.
- `locked` rises at the same edge as the `period_valid` of the `LOCK_CNT`-th consecutive match.
- `locked` falls at the same edge as the mismatching `period_valid`, or at the timeout edge.
- `mismatch` and `period_valid` assert together for a bad period. `mismatch` never asserts without `period_valid`.
- Minimum resolvable period: 2 cycles. Narrower pulses may be missed by the synchronizer; this is acceptable.

## Test plan
- **Reset:** hold `reset` 3 cycles with `sig_in` toggling → all outputs 0, no `period_valid` during or the cycle after reset.
- **Divide-by-3 lock (defaults):** `sig_in` 1 cycle high / 2 low, synchronous to `clk`.
  - First rise gives no pulse.
  - Then `period_valid` every 3 cycles with `period=3`, `high_time=1`.
  - `locked=1` at the 4th pulse.
- **Period change:** from lock, switch to 2 high / 2 low.
  - `period_valid` + `mismatch` with `period=4`, `high_time=2`; `locked=0` at that edge.
  - Returning to divide-by-3 relocks after 4 matches.
- **Tolerance:** `TOL=1`, drive period 4 → 4 matches, `locked=1`, `mismatch` never asserts. Period 5 → `mismatch`.
- **Timeout:** from lock, hold `sig_in` low.
  - 255 cycles after the last rise, `timeout_err=1`, `locked=0`.
  - Resume toggling → `timeout_err` stays 1 and lock re-acquires.
  - `clear` → `timeout_err=0` and `locked=0` next edge.
- **Clear vs. edge:** assert `clear` in the cycle `rise` is true → no `period_valid` at the next rise; the second subsequent rise produces the first `period_valid`.

Source files
------------

// File: rtl/period_monitor.sv
// period_monitor: receive-side period/frequency checker for a square wave.
// The input is synchronized, and its rising edges are found in the clk domain.
// The monitor measures the period and the high time between rising edges. It
// declares lock after LOCK_CNT consecutive in-tolerance periods. If no edge
// arrives within TIMEOUT cycles, it raises a sticky timeout flag.
//
// Ports:
//   clk_i          single clock
//   reset_i        synchronous active-high reset
//   sig_in_i       monitored signal (asynchronous)
//   clear_i        drop lock, clear timeout_err_o, return to SEEK
//   period_o       last measured period in clk cycles
//   high_time_o    cycles the signal was high during the last period
//   period_valid_o one-cycle pulse when period_o/high_time_o update
//   mismatch_o     one-cycle pulse: last period out of tolerance
//   locked_o       FSM is in LOCKED
//   timeout_err_o  sticky missing-edge flag
module period_monitor #(
  parameter int CNT_W      = 8,
  parameter int EXP_PERIOD = 3,
  parameter int TOL        = 0,
  parameter int LOCK_CNT   = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             sig_in_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_time_o,
  output logic             period_valid_o,
  output logic             mismatch_o,
  output logic             locked_o,
  output logic             timeout_err_o
);

  localparam int                MC_W   = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]  TO_C   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  HMAX_C = '1;
  localparam logic [CNT_W:0]    EXP_C  = (CNT_W+1)'(EXP_PERIOD);
  localparam logic [CNT_W:0]    TOL_C  = (CNT_W+1)'(TOL);
  localparam logic [MC_W-1:0]   LOCK_C = MC_W'(LOCK_CNT);

  typedef enum logic [1:0] {SEEK, MEASURE, LOCKED} state_e;

  logic             s1_q, s2_q, s3_q;
  logic             rise;
  logic [CNT_W-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d;
  logic [CNT_W:0]   per_x, diff;
  logic             match, tmo;
  logic [MC_W-1:0]  mc_q, mc_inc;
  state_e           state_q;
  logic [CNT_W-1:0] period_q, high_time_q;
  logic             pv_q, mm_q, locked_q, terr_q;

  assign rise = s2_q & ~s3_q;

  // cnt saturates at TIMEOUT so that it can never wrap past the timeout point.
  always_comb begin
    cnt_d  = cnt_q;
    hcnt_d = hcnt_q;
    if (rise) begin
      cnt_d  = CNT_W'(1);
      hcnt_d = CNT_W'(1);
    end else begin
      if (cnt_q != TO_C)          cnt_d  = cnt_q + CNT_W'(1);
      if (s2_q && hcnt_q != HMAX_C) hcnt_d = hcnt_q + CNT_W'(1);
    end
  end

  // The absolute deviation uses one extra bit, so a small period below
  // EXP_PERIOD does not wrap into a huge value.
  always_comb begin
    per_x = {1'b0, cnt_q};
    diff  = (per_x >= EXP_C) ? (per_x - EXP_C) : (EXP_C - per_x);
    match = (diff <= TOL_C);
  end

  assign tmo    = (state_q != SEEK) && (cnt_q == TO_C) && !rise;
  assign mc_inc = mc_q + MC_W'(1);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      cnt_q  <= '0;
      hcnt_q <= '0;
    end else begin
      s1_q   <= sig_in_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      cnt_q  <= cnt_d;
      hcnt_q <= hcnt_d;
    end
  end

  // Lock FSM with registered status outputs. Order of precedence:
  // clear, then timeout, then rise.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= SEEK;
      mc_q        <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      pv_q        <= 1'b0;
      mm_q        <= 1'b0;
      locked_q    <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      pv_q <= 1'b0;
      mm_q <= 1'b0;
      if (clear_i) begin
        // A rise in this cycle is dropped; the next rise becomes the new reference.
        state_q  <= SEEK;
        mc_q     <= '0;
        locked_q <= 1'b0;
        terr_q   <= 1'b0;
      end else if (tmo) begin
        state_q  <= SEEK;
        mc_q     <= '0;
        locked_q <= 1'b0;
        terr_q   <= 1'b1;
      end else if (rise) begin
        case (state_q)
          SEEK: state_q <= MEASURE;
          MEASURE, LOCKED: begin
            period_q    <= cnt_q;
            high_time_q <= hcnt_q;
            pv_q        <= 1'b1;
            if (match) begin
              if (state_q == MEASURE) begin
                mc_q <= mc_inc;
                if (mc_inc == LOCK_C) begin
                  state_q  <= LOCKED;
                  locked_q <= 1'b1;
                end
              end
            end else begin
              state_q  <= MEASURE;
              mc_q     <= '0;
              mm_q     <= 1'b1;
              locked_q <= 1'b0;
            end
          end
          default: state_q <= SEEK;
        endcase
      end
    end
  end

  assign period_o       = period_q;
  assign high_time_o    = high_time_q;
  assign period_valid_o = pv_q;
  assign mismatch_o     = mm_q;
  assign locked_o       = locked_q;
  assign timeout_err_o  = terr_q;

endmodule

// File: tb/tb_period_monitor.sv
// Bench for period_monitor. Two instances run side by side: TOL=0 and TOL=1.
// The reference model tracks the sampled input history. It finds each rising
// sample and takes the period as the gap to the previous rising sample. The
// high time is the number of high samples in that window. Each result is
// expected two edges after the rising sample.
module tb_period_monitor;
  localparam int CNT_W = 8, EXP_P = 3, LOCK_N = 4, TMO = 255;

  logic clk = 1'b0;
  logic reset, sig_in, clear;
  logic [CNT_W-1:0] per0, ht0, per1, ht1;
  logic pv0, mm0, lk0, te0, pv1, mm1, lk1, te1;

  always #5 clk = ~clk;

  period_monitor #(.CNT_W(CNT_W), .EXP_PERIOD(EXP_P), .TOL(0), .LOCK_CNT(LOCK_N), .TIMEOUT(TMO)) u0 (
    .clk_i(clk), .reset_i(reset), .sig_in_i(sig_in), .clear_i(clear),
    .period_o(per0), .high_time_o(ht0), .period_valid_o(pv0), .mismatch_o(mm0),
    .locked_o(lk0), .timeout_err_o(te0));

  period_monitor #(.CNT_W(CNT_W), .EXP_PERIOD(EXP_P), .TOL(1), .LOCK_CNT(LOCK_N), .TIMEOUT(TMO)) u1 (
    .clk_i(clk), .reset_i(reset), .sig_in_i(sig_in), .clear_i(clear),
    .period_o(per1), .high_time_o(ht1), .period_valid_o(pv1), .mismatch_o(mm1),
    .locked_o(lk1), .timeout_err_o(te1));

  typedef struct {
    int st;       // 0 seek, 1 measuring, 2 locked
    int mc;
    int last_r;   // sample index of the previous rising sample
    logic [7:0] per, ht;
    logic pv, mm, lk, te;
  } m_t;

  logic samp[$];
  m_t m0, m1;
  int nchk = 0, nfail = 0;
  int pv0_cnt = 0, mm0_cnt = 0, mm1_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic mdl(inout m_t m, input int tol, input logic r, input logic c);
    int n, j, gap, hc;
    logic rise;
    m.pv = 1'b0;
    m.mm = 1'b0;
    if (r) begin
      m.st = 0; m.mc = 0; m.last_r = -100000;
      m.per = '0; m.ht = '0; m.lk = 1'b0; m.te = 1'b0;
      return;
    end
    n = samp.size() - 1;
    j = n - 2;
    rise = (j >= 1) && samp[j] && !samp[j-1];
    if (c) begin
      m.st = 0; m.mc = 0; m.lk = 1'b0; m.te = 1'b0;
    end else if (m.st != 0 && !rise && (j - m.last_r) >= TMO) begin
      m.st = 0; m.mc = 0; m.lk = 1'b0; m.te = 1'b1;
    end else if (rise) begin
      if (m.st == 0) m.st = 1;
      else begin
        gap = j - m.last_r;
        hc = 0;
        for (int k = m.last_r; k < j; k++) hc += int'(samp[k]);
        m.per = gap[7:0];
        m.ht  = (hc > 255) ? 8'd255 : hc[7:0];
        m.pv  = 1'b1;
        if ((gap >= EXP_P ? gap - EXP_P : EXP_P - gap) <= tol) begin
          if (m.st == 1) begin
            m.mc++;
            if (m.mc == LOCK_N) begin m.st = 2; m.lk = 1'b1; end
          end
        end else begin
          m.mc = 0; m.mm = 1'b1; m.st = 1; m.lk = 1'b0;
        end
      end
    end
    if (rise) m.last_r = j;
  endtask

  // One clock: drive inputs, advance the model at the edge, and check just after it.
  task automatic cyc(input logic s, input logic c, input logic r);
    sig_in = s; clear = c; reset = r;
    @(posedge clk);
    samp.push_back(r ? 1'b0 : s);
    if (r && samp.size() > 1) samp[samp.size()-2] = 1'b0;
    mdl(m0, 0, r, c);
    mdl(m1, 1, r, c);
    #1;
    chk("period0", 32'(per0), 32'(m0.per));
    chk("high0",   32'(ht0),  32'(m0.ht));
    chk("pv0",     32'(pv0),  32'(m0.pv));
    chk("mm0",     32'(mm0),  32'(m0.mm));
    chk("lock0",   32'(lk0),  32'(m0.lk));
    chk("tmo0",    32'(te0),  32'(m0.te));
    chk("period1", 32'(per1), 32'(m1.per));
    chk("high1",   32'(ht1),  32'(m1.ht));
    chk("pv1",     32'(pv1),  32'(m1.pv));
    chk("mm1",     32'(mm1),  32'(m1.mm));
    chk("lock1",   32'(lk1),  32'(m1.lk));
    chk("tmo1",    32'(te1),  32'(m1.te));
    if (pv0 === 1'b1) pv0_cnt++;
    if (mm0 === 1'b1) mm0_cnt++;
    if (mm1 === 1'b1) mm1_cnt++;
  endtask

  task automatic wave(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < hi; i++) cyc(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < lo; i++) cyc(1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int hi, lo;
    sig_in = 1'b0; clear = 1'b0; reset = 1'b1;
    // Reset with the input toggling, then one quiet cycle.
    for (int i = 0; i < 3; i++) cyc(1'(i % 2), 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);

    // Divide-by-3: lock at the 4th period_valid.
    pv0_cnt = 0;
    for (int i = 0; i < 20 && lk0 !== 1'b1; i++) wave(1, 2, 1);
    chk("lock_at_pulse", 32'(pv0_cnt), 32'(LOCK_N));
    chk("locked_div3", 32'(lk0), 32'd1);
    wave(1, 2, 3);

    // Period change to 4 drops lock on the first bad period.
    mm0_cnt = 0;
    wave(2, 2, 2);
    chk("chg_mm_cnt", 32'(mm0_cnt), 32'd1);
    chk("chg_period", 32'(per0), 32'd4);
    chk("chg_high", 32'(ht0), 32'd2);
    chk("chg_unlock", 32'(lk0), 32'd0);
    wave(2, 2, 3);
    wave(1, 2, 6);
    chk("relock", 32'(lk0), 32'd1);

    // Tolerance: TOL=1 accepts period 4 and rejects period 5.
    mm1_cnt = 0;
    wave(2, 2, 6);
    chk("tol_no_mm", 32'(mm1_cnt), 32'd0);
    chk("tol_locked", 32'(lk1), 32'd1);
    wave(2, 3, 2);
    chk("tol_mm5", 32'(mm1_cnt), 32'd1);
    wave(1, 2, 8);

    // Timeout from lock, sticky through relock, then clear.
    for (int i = 0; i < 260; i++) cyc(1'b0, 1'b0, 1'b0);
    chk("tmo_set", 32'(te0), 32'd1);
    chk("tmo_unlock", 32'(lk0), 32'd0);
    wave(1, 2, 8);
    chk("tmo_sticky", 32'(te0), 32'd1);
    chk("tmo_relock", 32'(lk0), 32'd1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("clr_tmo", 32'(te0), 32'd0);
    chk("clr_lock", 32'(lk0), 32'd0);

    // Clear in the same cycle as a rise: that rise is discarded.
    wave(1, 2, 6);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    pv0_cnt = 0;
    wave(1, 2, 1);
    chk("clr_edge_ref", 32'(pv0_cnt), 32'd0);
    wave(1, 2, 1);
    chk("clr_edge_first", 32'(pv0_cnt), 32'd1);

    // Random waveforms with occasional long gaps near TIMEOUT, clears and resets.
    for (int it = 0; it < 250; it++) begin
      hi = $urandom_range(1, 4);
      lo = ($urandom_range(0, 19) == 0) ? $urandom_range(250, 262) : $urandom_range(1, 4);
      if ($urandom_range(0, 199) == 0) cyc(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < hi; i++) cyc(1'b1, 1'($urandom_range(0, 39) == 0), 1'b0);
      for (int i = 0; i < lo; i++) cyc(1'b0, 1'($urandom_range(0, 39) == 0), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
